// File: rtl/min_pop_scheduler.sv
// Priority scheduler: 128-slot key table, pops the smallest valid key
// through a registered search stage over a combinational min-finder.
module min_pop_scheduler #(
    parameter int              ENTRIES  = 128,
    parameter int              KEY_W    = 16,
    parameter logic [KEY_W-1:0] SENTINEL = 16'hFFFF
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       CLEAR,
    input  logic                       WR_EN,
    input  logic [$clog2(ENTRIES)-1:0] WR_ADDR,
    input  logic [KEY_W-1:0]           WR_KEY,
    output logic                       WR_ERR,
    input  logic                       POP_REQ,
    output logic                       POP_VALID,
    output logic                       POP_NONE,
    output logic [$clog2(ENTRIES)-1:0] POP_INDEX,
    output logic [KEY_W-1:0]           POP_KEY,
    output logic [$clog2(ENTRIES):0]   COUNT,
    output logic                       EMPTY,
    output logic                       BUSY
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int HALF  = ENTRIES / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [KEY_W-1:0]   keys   [ENTRIES];
    logic [ENTRIES-1:0] valid;
    logic [KEY_W-1:0]   masked [ENTRIES];
    logic [KEY_W-1:0]   lo_key;
    logic [KEY_W-1:0]   hi_key;
    logic [KEY_W-1:0]   find_key;
    logic [IDX_W-1:0]   lo_idx;
    logic [IDX_W-1:0]   hi_idx;
    logic [IDX_W-1:0]   find_idx;
    logic               wr_ok;
    logic               wr_bad;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            masked[i] = valid[i] ? keys[i] : SENTINEL;
        end
    end

    // Scanning downward with <= leaves the lowest index of each half on ties;
    // the upper half then wins an equal comparison between halves.
    always_comb begin
        lo_key = masked[HALF-1];
        lo_idx = IDX_W'(HALF - 1);
        for (int i = HALF - 2; i >= 0; i--) begin
            if (masked[i] <= lo_key) begin
                lo_key = masked[i];
                lo_idx = IDX_W'(i);
            end
        end
        hi_key = masked[ENTRIES-1];
        hi_idx = IDX_W'(ENTRIES - 1);
        for (int i = ENTRIES - 2; i >= HALF; i--) begin
            if (masked[i] <= hi_key) begin
                hi_key = masked[i];
                hi_idx = IDX_W'(i);
            end
        end
        if (hi_key <= lo_key) begin
            find_key = hi_key;
            find_idx = hi_idx;
        end else begin
            find_key = lo_key;
            find_idx = lo_idx;
        end
    end

    assign wr_ok  = WR_EN && (state == IDLE) && (WR_KEY != SENTINEL);
    assign wr_bad = WR_EN && ((state != IDLE) || (WR_KEY == SENTINEL));
    assign EMPTY  = (COUNT == '0);
    assign BUSY   = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (POP_REQ && COUNT != '0) state_next = SEARCH;
            SEARCH:  state_next = RESULT;
            RESULT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            valid     <= '0;
            keys      <= '{default: '0};
            COUNT     <= '0;
            WR_ERR    <= 1'b0;
            POP_VALID <= 1'b0;
            POP_NONE  <= 1'b0;
            POP_INDEX <= '0;
            POP_KEY   <= '0;
        end else if (CLEAR) begin
            state     <= IDLE;
            valid     <= '0;
            COUNT     <= '0;
            WR_ERR    <= 1'b0;
            POP_VALID <= 1'b0;
            POP_NONE  <= 1'b0;
        end else begin
            state     <= state_next;
            WR_ERR    <= wr_bad;
            POP_VALID <= (state == SEARCH);
            POP_NONE  <= (state == IDLE) && POP_REQ && (COUNT == '0);
            if (wr_ok) begin
                keys[WR_ADDR]  <= WR_KEY;
                valid[WR_ADDR] <= 1'b1;
                if (!valid[WR_ADDR]) COUNT <= COUNT + 1'b1;
            end
            if (state == SEARCH) begin
                POP_INDEX <= find_idx;
                POP_KEY   <= find_key;
            end
            if (state == RESULT) begin
                valid[POP_INDEX] <= 1'b0;
                COUNT            <= COUNT - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_min_pop_scheduler.sv
// Directed bench for min_pop_scheduler: pop ordering, tie-break,
// write errors, full table, CLEAR abort and same-cycle write+pop.
module tb_min_pop_scheduler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CLEAR;
    logic        WR_EN;
    logic [6:0]  WR_ADDR;
    logic [15:0] WR_KEY;
    logic        WR_ERR;
    logic        POP_REQ;
    logic        POP_VALID;
    logic        POP_NONE;
    logic [6:0]  POP_INDEX;
    logic [15:0] POP_KEY;
    logic [7:0]  COUNT;
    logic        EMPTY;
    logic        BUSY;

    int n_assert = 0;
    int n_fail   = 0;

    min_pop_scheduler dut (
        .Clk(Clk), .Reset(Reset), .CLEAR(CLEAR),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_KEY(WR_KEY), .WR_ERR(WR_ERR),
        .POP_REQ(POP_REQ), .POP_VALID(POP_VALID), .POP_NONE(POP_NONE),
        .POP_INDEX(POP_INDEX), .POP_KEY(POP_KEY),
        .COUNT(COUNT), .EMPTY(EMPTY), .BUSY(BUSY)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [15:0] k);
        WR_EN = 1'b1; WR_ADDR = a; WR_KEY = k;
        tick();
        WR_EN = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [6:0] idx, input logic [15:0] key);
        POP_REQ = 1'b1;
        tick();
        POP_REQ = 1'b0;
        chk({tag, "_early"}, 32'(POP_VALID), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(POP_VALID), 32'd1);
        chk({tag, "_idx"}, 32'(POP_INDEX), 32'(idx));
        chk({tag, "_key"}, 32'(POP_KEY), 32'(key));
        tick();
        chk({tag, "_pulse"}, 32'(POP_VALID), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; CLEAR = 1'b0; WR_EN = 1'b0; WR_ADDR = '0;
        WR_KEY = '0; POP_REQ = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_pv", 32'(POP_VALID), 32'd0);
        chk("rst_pn", 32'(POP_NONE), 32'd0);
        chk("rst_werr", 32'(WR_ERR), 32'd0);
        chk("rst_idx", 32'(POP_INDEX), 32'd0);
        chk("rst_key", 32'(POP_KEY), 32'd0);

        // empty pop
        tick();
        POP_REQ = 1'b1;
        tick();
        POP_REQ = 1'b0;
        chk("none_pulse", 32'(POP_NONE), 32'd1);
        chk("none_pv", 32'(POP_VALID), 32'd0);
        chk("none_busy", 32'(BUSY), 32'd0);
        tick();
        chk("none_end", 32'(POP_NONE), 32'd0);
        chk("none_empty", 32'(EMPTY), 32'd1);

        // ordering
        wr(7'd5, 16'h0300);
        wr(7'd77, 16'h0010);
        wr(7'd120, 16'h0200);
        chk("ord_cnt3", 32'(COUNT), 32'd3);
        pop("ord1", 7'd77, 16'h0010);
        chk("ord_cnt2", 32'(COUNT), 32'd2);
        pop("ord2", 7'd120, 16'h0200);
        chk("ord_cnt1", 32'(COUNT), 32'd1);
        pop("ord3", 7'd5, 16'h0300);
        chk("ord_cnt0", 32'(COUNT), 32'd0);
        chk("ord_empty", 32'(EMPTY), 32'd1);

        // tie-break
        wr(7'd2, 16'h0040);
        wr(7'd9, 16'h0040);
        wr(7'd70, 16'h0040);
        pop("tie1", 7'd70, 16'h0040);
        pop("tie2", 7'd2, 16'h0040);
        pop("tie3", 7'd9, 16'h0040);
        chk("tie_cnt", 32'(COUNT), 32'd0);

        // write while busy
        wr(7'd10, 16'h0100);
        wr(7'd20, 16'h0050);
        chk("busy_cnt2", 32'(COUNT), 32'd2);
        POP_REQ = 1'b1;
        tick();
        POP_REQ = 1'b0;
        chk("busy_hi", 32'(BUSY), 32'd1);
        WR_EN = 1'b1; WR_ADDR = 7'd30; WR_KEY = 16'h0001;
        tick();
        WR_EN = 1'b0;
        chk("busy_werr", 32'(WR_ERR), 32'd1);
        chk("busy_pv", 32'(POP_VALID), 32'd1);
        chk("busy_idx", 32'(POP_INDEX), 32'd20);
        chk("busy_key", 32'(POP_KEY), 32'h0050);
        tick();
        chk("busy_werr_end", 32'(WR_ERR), 32'd0);
        chk("busy_cnt1", 32'(COUNT), 32'd1);
        pop("busy_next", 7'd10, 16'h0100);

        // sentinel key rejected
        wr(7'd3, 16'hFFFF);
        chk("sent_werr", 32'(WR_ERR), 32'd1);
        chk("sent_cnt", 32'(COUNT), 32'd0);

        // overwrite
        wr(7'd40, 16'h0500);
        chk("ovw_werr", 32'(WR_ERR), 32'd0);
        chk("ovw_cnt1", 32'(COUNT), 32'd1);
        wr(7'd40, 16'h0020);
        chk("ovw_cnt1b", 32'(COUNT), 32'd1);
        wr(7'd41, 16'h0030);
        chk("ovw_cnt2", 32'(COUNT), 32'd2);
        pop("ovw1", 7'd40, 16'h0020);
        pop("ovw2", 7'd41, 16'h0030);
        chk("ovw_cnt0", 32'(COUNT), 32'd0);

        // full table then CLEAR during SEARCH
        for (int i = 0; i < 128; i++) begin
            wr(7'(i), 16'(127 - i));
        end
        chk("full_cnt", 32'(COUNT), 32'd128);
        chk("full_empty", 32'(EMPTY), 32'd0);
        pop("full1", 7'd127, 16'h0000);
        chk("full_cnt127", 32'(COUNT), 32'd127);
        POP_REQ = 1'b1;
        tick();
        POP_REQ = 1'b0;
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        chk("clr_pv", 32'(POP_VALID), 32'd0);
        chk("clr_cnt", 32'(COUNT), 32'd0);
        chk("clr_busy", 32'(BUSY), 32'd0);
        chk("clr_empty", 32'(EMPTY), 32'd1);
        chk("clr_idx_hold", 32'(POP_INDEX), 32'd127);
        tick();
        chk("clr_pv2", 32'(POP_VALID), 32'd0);

        // same-cycle write and pop
        wr(7'd50, 16'h0005);
        WR_EN = 1'b1; WR_ADDR = 7'd0; WR_KEY = 16'h0001; POP_REQ = 1'b1;
        tick();
        WR_EN = 1'b0; POP_REQ = 1'b0;
        chk("same_werr", 32'(WR_ERR), 32'd0);
        tick();
        chk("same_pv", 32'(POP_VALID), 32'd1);
        chk("same_idx", 32'(POP_INDEX), 32'd0);
        chk("same_key", 32'(POP_KEY), 32'h0001);
        tick();
        chk("same_cnt", 32'(COUNT), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/min_pop_scheduler.md
Name: min_pop_scheduler

Overview:
- Sequencing controller wrapped around the 128-entry, 16-bit combinational minimum-finder datapath.
- Holds a 128-slot key table with per-slot valid bits, and presents it to the finder with invalid slots masked.
- Serves one "pop the smallest valid key" request at a time, using a registered search stage. Each pop returns the winning slot index and key, then invalidates that slot.
- Acts as a small priority scheduler, e.g. for nearest-distance or earliest-deadline selection.

Parameters:
- ENTRIES, 128, number of key slots. Fixed by the finder datapath; other values unsupported.
- KEY_W, 16, key width in bits. Fixed by the finder datapath.
- SENTINEL, 16'hFFFF, value driven into the finder for invalid slots. Reserved; not a legal key.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- CLEAR  in  1  synchronous flush of all slots; aborts any pop in flight.
- WR_EN  in  1  write strobe.
- WR_ADDR  in  7  slot to write.
- WR_KEY  in  16  key to write; legal range 0..16'hFFFE.
- WR_ERR  out  1  one-cycle pulse: write rejected.
- POP_REQ  in  1  request to extract the minimum valid key.
- POP_VALID  out  1  one-cycle pulse: POP_INDEX/POP_KEY valid.
- POP_NONE  out  1  one-cycle pulse: pop requested while table empty.
- POP_INDEX  out  7  slot index of the popped key.
- POP_KEY  out  16  popped key value.
- COUNT  out  8  number of valid slots, 0..128.
- EMPTY  out  1  COUNT == 0.
- BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (sync, highest priority):
  - all valid bits 0, keys 0, state IDLE;
  - COUNT=0, EMPTY=1, BUSY=0;
  - POP_VALID, POP_NONE, WR_ERR = 0; POP_INDEX=0, POP_KEY=0.
- CLEAR (next priority):
  - same effect as Reset on valid bits, COUNT, state and all pulses;
  - keys and POP_INDEX/POP_KEY hold their values;
  - an in-flight pop produces no POP_VALID;
  - a WR_EN or POP_REQ in the same cycle is ignored.
- Finder input: slot i carries KEY[i] if VALID[i], else SENTINEL. The finder is purely combinational; its outputs are never used unregistered.
- FSM states: IDLE, SEARCH, RESULT.
- IDLE:
  - POP_REQ with COUNT>0 -> SEARCH.
  - POP_REQ with COUNT==0 -> POP_NONE pulses the next cycle; state stays IDLE.
- SEARCH (one cycle): finder index and number are captured into POP_INDEX/POP_KEY at the end of the cycle -> RESULT.
- RESULT (one cycle):
  - POP_VALID=1;
  - VALID[POP_INDEX] cleared at the closing edge; COUNT decremented;
  - -> IDLE.
- Pop latency: POP_REQ sampled at edge N -> POP_VALID high during cycle N+2. Throughput is one pop per 3 cycles.
- POP_REQ while BUSY is ignored; it is not queued. The requester holds or re-issues after POP_VALID/POP_NONE.
- Writes are accepted only in IDLE:
  - sets KEY[WR_ADDR]=WR_KEY and VALID=1;
  - COUNT increments only if the slot was previously invalid; overwriting a valid slot leaves COUNT unchanged.
- WR_ERR pulses the next cycle, with no state change, when:
  - WR_EN is asserted while BUSY, or
  - WR_KEY == SENTINEL.
- Simultaneous WR_EN and POP_REQ in IDLE: the write commits at the same edge the FSM enters SEARCH, so the search sees the new key.
- COUNT never wraps: a write can reach 128 only by filling every slot, and the empty check prevents decrement below 0.
- Tie-break among equal minimum keys follows the datapath exactly:
  - lowest index within each 8-slot group;
  - lowest group within each 64-slot half;
  - between the halves, the upper half (slots 64..127) wins on equality.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then POP_REQ -> POP_NONE=1 two cycles after release of reset; COUNT=0, EMPTY=1, no POP_VALID.
- Write slot 5=0x0300, slot 77=0x0010, slot 120=0x0200; pop three times -> returns (77,0x0010), (120,0x0200), (5,0x0300) in that order, each with POP_VALID exactly 2 cycles after POP_REQ. COUNT goes 3->2->1->0, then EMPTY=1.
- Tie-break: slot 2=0x0040, slot 9=0x0040, slot 70=0x0040 -> first pop returns index 70, second returns 2, third returns 9.
- Protocol errors:
  - WR_EN while BUSY (during SEARCH) -> WR_ERR pulse, and the table is unchanged at the next pop;
  - WR_KEY=0xFFFF in IDLE -> WR_ERR pulse, COUNT unchanged;
  - overwrite a valid slot with a new key -> COUNT unchanged, and the new key is the one popped.
- Fill all 128 slots with key=127-i -> COUNT=128; first pop returns (127,0x0000). Then assert CLEAR during SEARCH -> no POP_VALID, COUNT=0, BUSY=0 the next cycle.
- Same-cycle WR_EN(slot 0, 0x0001) and POP_REQ, with slot 50=0x0005 already valid -> pop returns (0,0x0001); COUNT ends at 1.
